// File: rtl/mem_read_arbiter.sv
// Purpose : round-robin share of one AXI-style read channel (AR + R) between NUM_REQ read masters.
// Latency : request seen in IDLE at cycle t gives m_arvalid at t+1; one IDLE bubble between bursts.
// Backpr. : AR waits on m_arready; R beats stall while the granted master holds req_rready low.
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   req_arvalid/araddr/arlen/arid      per-master read requests (master i at slice i)
//   req_arready                        per-master address accept, pulses with m_arready
//   req_rvalid, req_rdata, req_rready  per-master read data (data bus shared)
//   m_ar*, m_r*                        memory-side read channel
//   grant                              one-hot current owner, 0 when idle
//   busy                               burst in progress (not IDLE)
module mem_read_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 4,
   localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_arvalid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
   input  logic [NUM_REQ*ID_WIDTH-1:0]   req_arid,
   output logic [NUM_REQ-1:0]            req_arready,
   output logic [NUM_REQ-1:0]            req_rvalid,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   input  logic [NUM_REQ-1:0]            req_rready,
   output logic                          m_arvalid,
   output logic [ADDR_WIDTH-1:0]         m_araddr,
   output logic [LEN_WIDTH-1:0]          m_arlen,
   output logic [ID_WIDTH-1:0]           m_arid,
   input  logic                          m_arready,
   input  logic                          m_rvalid,
   input  logic [DATA_WIDTH-1:0]         m_rdata,
   output logic                          m_rready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [PTR_WIDTH-1:0] grant_idx, grant_idx_nxt;
   logic [NUM_REQ-1:0]   grant_nxt;
   logic [PTR_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
   logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_nxt;

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   logic                 pick_vld;
   logic [PTR_WIDTH-1:0] pick_idx;
   logic [LEN_WIDTH-1:0] pick_len;
   int                   cand;

   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      pick_len = '0;
      cand     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % NUM_REQ;
         if (!pick_vld && req_arvalid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = PTR_WIDTH'(cand);
            pick_len = req_arlen[cand*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   // Fields of the granted master, muxed on the registered index.
   logic sel_rready;

   always_comb begin
      m_araddr   = '0;
      m_arlen    = '0;
      m_arid     = '0;
      sel_rready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PTR_WIDTH'(i)) begin
            m_araddr   = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_arlen    = req_arlen[i*LEN_WIDTH +: LEN_WIDTH];
            m_arid     = req_arid[i*ID_WIDTH +: ID_WIDTH];
            sel_rready = req_rready[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant_idx <= '0;
         grant     <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_idx_nxt;
         grant     <= grant_nxt;
         rr_ptr    <= rr_ptr_nxt;
         beat_cnt  <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_idx_nxt = grant_idx;
      grant_nxt     = grant;
      rr_ptr_nxt    = rr_ptr;
      beat_cnt_nxt  = beat_cnt;
      m_arvalid     = 1'b0;
      m_rready      = 1'b0;
      req_arready   = '0;
      req_rvalid    = '0;

      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt           = ADDR;
               grant_idx_nxt       = pick_idx;
               grant_nxt           = '0;
               grant_nxt[pick_idx] = 1'b1;
               // A zero length still moves one beat.
               beat_cnt_nxt        = (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
            end
         end

         ADDR: begin
            // Held high even if the owner misbehaves and drops arvalid.
            m_arvalid = 1'b1;
            if (m_arready) begin
               req_arready = grant;
               state_nxt   = DATA;
            end
         end

         DATA: begin
            m_rready = sel_rready;
            if (m_rvalid) begin
               req_rvalid = grant;
            end
            if (m_rvalid && sel_rready) begin
               beat_cnt_nxt = beat_cnt - LEN_WIDTH'(1);
               if (beat_cnt == LEN_WIDTH'(1)) begin
                  state_nxt  = IDLE;
                  grant_nxt  = '0;
                  rr_ptr_nxt = (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + PTR_WIDTH'(1);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign req_rdata = m_rdata;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_arvalid = '0;
   logic [N*AW-1:0] req_araddr = '0;
   logic [N*LW-1:0] req_arlen = '0;
   logic [N*IW-1:0] req_arid = '0;
   logic [N-1:0]    req_arready;
   logic [N-1:0]    req_rvalid;
   logic [DW-1:0]   req_rdata;
   logic [N-1:0]    req_rready = '1;
   logic            m_arvalid;
   logic [AW-1:0]   m_araddr;
   logic [LW-1:0]   m_arlen;
   logic [IW-1:0]   m_arid;
   logic            m_arready = 1'b0;
   logic            m_rvalid = 1'b0;
   logic [DW-1:0]   m_rdata = '0;
   logic            m_rready;
   logic [N-1:0]    grant;
   logic            busy;

   always #5 clk = ~clk;

   mem_read_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
      .req_arid(req_arid), .req_arready(req_arready),
      .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rready(req_rready),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
      .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
      .grant(grant), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int model_ptr = 0;   // reference round-robin pointer
   int burst_no  = 0;

   typedef struct {
      logic [2:0]  mask;
      logic [11:0] lens;
      logic [2:0]  exp_grant;
      int          exp_beats;
      int          ar_delay;
      int          stall_at;
      int          stall_len;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arbitration rule: first requester at or after ptr, modulo N.
   function automatic int rr_pick(input logic [2:0] mask, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Entered and left at a negedge.
   task automatic do_reset();
      rst_n       = 1'b0;
      req_arvalid = '1;
      req_rready  = '1;
      m_arready   = 1'b1;
      m_rvalid    = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {m_arvalid, m_rready, req_arready, req_rvalid, busy, grant}, '0);
      rst_n       = 1'b1;
      req_arvalid = '0;
      m_arready   = 1'b0;
      @(negedge clk);
      chk("stray_beat_idle", {m_rready, req_rvalid, busy}, '0);
      m_rvalid  = 1'b0;
      model_ptr = 0;
   endtask

   task automatic run_burst(input logic [2:0] mask, input logic [11:0] lens,
                            input logic [2:0] exp_grant, input int exp_beats,
                            input int ar_delay, input int stall_at, input int stall_len,
                            input int rst_at, input bit rnd);
      int g, got, cyc, stall_left;
      logic [N-1:0]  rr;
      logic [DW-1:0] bdat;
      g = 0;
      for (int i = 0; i < N; i++) if (exp_grant[i]) g = i;
      burst_no++;
      for (int i = 0; i < N; i++) begin
         req_araddr[i*AW +: AW] = $urandom;
         req_arid[i*IW +: IW]   = IW'($urandom);
      end
      req_arlen   = lens;
      req_arvalid = mask;
      req_rready  = '1;
      m_arready   = 1'b0;
      m_rvalid    = 1'b0;
      @(negedge clk);
      chk("ar_latency", m_arvalid, 1'b1);
      chk("grant", grant, exp_grant);
      if (m_arvalid !== 1'b1 || grant !== exp_grant) begin
         do_reset();
         return;
      end
      chk("ar_fields", {m_araddr, m_arlen, m_arid},
          {req_araddr[g*AW +: AW], lens[g*LW +: LW], req_arid[g*IW +: IW]});
      chk("arready_early", req_arready, '0);
      for (int d = 0; d < ar_delay; d++) begin
         @(negedge clk);
         chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, req_araddr[g*AW +: AW]});
         chk("arready_early", req_arready, '0);
      end
      m_arready = 1'b1;
      #1;
      chk("arready_pulse", req_arready, exp_grant);
      @(negedge clk);
      m_arready = 1'b0;
      #1;
      chk("ar_done", {m_arvalid, req_arready, busy}, {1'b0, 3'b000, 1'b1});
      // The others now request while the burst runs; they must not preempt.
      req_arvalid = ~exp_grant;

      got = 0;
      cyc = 0;
      stall_left = stall_len;
      while (got < exp_beats && cyc < 200) begin
         cyc++;
         m_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         bdat     = 32'hD000_0000 + DW'(burst_no << 8) + DW'(got);
         m_rdata  = bdat;
         rr       = rnd ? N'($urandom) : '1;
         if (got == stall_at && stall_left > 0) begin
            rr[g] = 1'b0;
            stall_left--;
         end
         req_rready = rr;
         #1;
         chk("busy_grant_data", {busy, grant}, {1'b1, exp_grant});
         chk("m_rready", m_rready, rr[g]);
         chk("req_rvalid", req_rvalid, m_rvalid ? exp_grant : 3'b000);
         if (m_rvalid) chk("req_rdata", req_rdata, bdat);
         if (m_rvalid && rr[g]) got++;
         @(negedge clk);
         if (rst_at != 0 && got == rst_at) begin
            do_reset();
            return;
         end
      end
      if (got < exp_beats) begin
         chk("data_timeout", got, exp_beats);
         do_reset();
         return;
      end
      req_arvalid = '0;
      req_rready  = '1;
      m_rvalid    = 1'b1;
      #1;
      chk("idle_after_burst", {busy, grant, m_rready, req_rvalid}, '0);
      model_ptr = (g + 1) % N;
   endtask

   initial begin
      logic [2:0]  mask;
      logic [11:0] lens;
      int          w, nb;

      vecs[0] = '{3'b001, 12'h444, 3'b001, 4, 0, 0, 0};
      vecs[1] = '{3'b111, 12'h444, 3'b010, 4, 5, 2, 3};
      vecs[2] = '{3'b111, 12'h244, 3'b100, 2, 1, 0, 0};
      vecs[3] = '{3'b111, 12'h440, 3'b001, 1, 0, 0, 0};
      vecs[4] = '{3'b101, 12'h144, 3'b100, 1, 2, 0, 1};
      vecs[5] = '{3'b010, 12'h4F4, 3'b010, 15, 0, 7, 2};
      vecs[6] = '{3'b011, 12'h443, 3'b001, 3, 0, 0, 0};
      vecs[7] = '{3'b001, 12'h444, 3'b001, 4, 3, 3, 1};

      do_reset();

      foreach (vecs[i]) begin
         run_burst(vecs[i].mask, vecs[i].lens, vecs[i].exp_grant, vecs[i].exp_beats,
                   vecs[i].ar_delay, vecs[i].stall_at, vecs[i].stall_len, 0, 1'b0);
      end

      // Pointer now sits at master 1; reset during beat 2 of master 1's burst
      // must send it back to 0, so {0,1} requesting then picks master 0.
      run_burst(3'b010, 12'h444, 3'b010, 4, 0, 0, 0, 2, 1'b0);
      run_burst(3'b011, 12'h444, 3'b001, 4, 1, 0, 0, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         mask = 3'($urandom_range(1, 7));
         lens = 12'($urandom);
         w    = rr_pick(mask, model_ptr);
         nb   = (lens[w*LW +: LW] == 0) ? 1 : int'(lens[w*LW +: LW]);
         run_burst(mask, lens, 3'b001 << w, nb, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
